ex_muldiv_unit: RTL and testbench

Execute-stage RV32M multiply/divide unit in the 5-stage pipeline, sitting directly downstream of the hazard unit's forwarding selects. It applies ForwardAE/ForwardBE to choose operands from the register file, the Memory stage or the Writeback stage. It then runs an iterative 32-step shift-add multiply or restoring divide. While the operation runs it holds the pipeline with a busy/stall output, and it presents the result to the E/M pipeline register.

---
 rtl/ex_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit: forwards operands, runs a 32-step
// shift-add multiply or restoring divide, and stalls the pipeline while busy.
module ex_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidE,
    input  logic            MdE,
    input  logic [2:0]      funct3E,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    output logic            MdBusy,
    output logic            MdDone,
    output logic [XLEN-1:0] MdResultE
);

    localparam int unsigned CW = $clog2(ITERS);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    logic [2:0]      op;
    logic            neg;
    logic [XLEN-1:0] opnd;      // multiplicand for MUL, divisor for DIV
    logic [2*XLEN-1:0] acc;     // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] out_q;

    logic [XLEN-1:0] opa, opb, ma, mb;
    logic            start, a_signed, b_signed, sa, sb, neg_n;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        case (ForwardAE)
            2'b01:   opa = ALUResultM;
            2'b10:   opa = ResultW;
            default: opa = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   opb = ALUResultM;
            2'b10:   opb = ResultW;
            default: opb = RD2E;
        endcase
    end

    assign start    = ValidE & MdE & ~FlushE;
    assign a_signed = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] == 2'b01 || funct3E[1:0] == 2'b10);
    assign b_signed = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] == 2'b01);
    assign sa       = a_signed & opa[XLEN-1];
    assign sb       = b_signed & opb[XLEN-1];
    assign ma       = sa ? -opa : opa;
    assign mb       = sb ? -opb : opb;
    // Remainder takes the dividend's sign; every other signed result is sa^sb.
    assign neg_n    = (funct3E[2] & funct3E[1]) ? sa : (sa ^ sb);

    assign div_zero = (opb == '0);
    assign div_ovf  = ~funct3E[0] & (opa == MIN_NEG) & (opb == '1);
    assign special  = funct3E[2] & (div_zero | div_ovf);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3E[1] ? opa : '1;
        else if (div_ovf)
            special_res = funct3E[1] ? '0 : MIN_NEG;
    end

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, step_acc, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        step_acc  = (state == DIV) ? div_next : mul_next;
        prod_fix  = neg ? -step_acc : step_acc;
        quo_fix   = neg ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem_fix   = neg ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        if (state == DIV)
            fin = op[1] ? rem_fix : quo_fix;
        else if (op[1:0] == 2'b00)
            fin = step_acc[XLEN-1:0];
        else
            fin = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op    <= '0;
            neg   <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op  <= funct3E;
                        neg <= neg_n;
                        cnt <= '0;
                        if (special) begin
                            res_q <= special_res;
                            state <= DONE;
                        end else if (funct3E[2]) begin
                            opnd  <= mb;
                            acc   <= {{XLEN{1'b0}}, ma};
                            state <= DIV;
                        end else begin
                            opnd  <= ma;
                            acc   <= {{XLEN{1'b0}}, mb};
                            state <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (FlushE) begin
                        state <= IDLE;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(ITERS - 1)) begin
                            res_q <= fin;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!FlushE)
                        out_q <= res_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flush and reset gate the outputs in the same cycle, so a squashed result never escapes.
    assign MdBusy    = ~reset & (((state == IDLE) & start) |
                                 (((state == MUL) | (state == DIV)) & ~FlushE));
    assign MdDone    = ~reset & (state == DONE) & ~FlushE;
    assign MdResultE = reset ? '0 : (MdDone ? res_q : out_q);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed spec cases plus randomized
// operations checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidE, MdE, FlushE;
    logic [2:0]  funct3E;
    logic [31:0] RD1E, RD2E, ALUResultM, ResultW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MdBusy, MdDone;
    logic [31:0] MdResultE;

    int n_cmp = 0;
    int n_fail = 0;

    ex_muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE), .MdE(MdE), .funct3E(funct3E),
        .FlushE(FlushE), .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM),
        .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MdDone(MdDone), .MdResultE(MdResultE)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              s;
        logic            ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                s = $signed(a) / $signed(b);
                return s;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                s = $signed(a) % $signed(b);
                return s;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd,
                                         input logic [31:0] m, input logic [31:0] w);
        return (sel == 2'b01) ? m : (sel == 2'b10) ? w : rd;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic idle_inputs();
        ValidE = 0; MdE = 0; FlushE = 0; funct3E = 0;
        ForwardAE = 0; ForwardBE = 0;
    endtask

    // Drives one M instruction held in E until MdDone; scrambles forward sources while stalled.
    task automatic do_op(input logic [2:0] f, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] alum, input logic [31:0] resw,
                         input logic [1:0] fa, input logic [1:0] fb,
                         output int lat, output logic [31:0] res,
                         output int busy_bad, output int after_bad);
        @(posedge clk); #1;
        funct3E = f; RD1E = rd1; RD2E = rd2; ALUResultM = alum; ResultW = resw;
        ForwardAE = fa; ForwardBE = fb; ValidE = 1; MdE = 1; FlushE = 0;
        lat = -1; res = 'x; busy_bad = 0; after_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (MdDone) begin
                lat = c; res = MdResultE;
                if (MdBusy) after_bad++;
                break;
            end
            if (!MdBusy) busy_bad++;
            @(posedge clk); #1;
            RD1E = $urandom; RD2E = $urandom; ALUResultM = $urandom; ResultW = $urandom;
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        if (MdDone || MdBusy) after_bad++;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        RD1E = 5; RD2E = 6; ALUResultM = 0; ResultW = 0;
        ValidE = 1; MdE = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", MdBusy); end
        n_cmp++; if (MdDone !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", MdDone); end
        n_cmp++; if (MdResultE !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", MdResultE); end
        @(posedge clk); #1;
        reset = 0; idle_inputs();
    endtask

    task automatic test_mul_basic();
        int lat, bb, ab; logic [31:0] res;
        do_op(3'd0, 32'd7, 32'd6, 32'd0, 32'd0, 2'b00, 2'b00, lat, res, bb, ab);
        n_cmp++; if (res !== 32'd42) begin n_fail++; $display("FAIL mul_result got %h want 0000002a", res); end
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got %0d want 33", lat); end
        n_cmp++; if (bb !== 0) begin n_fail++; $display("FAIL mul_busy_gaps got %0d want 0", bb); end
        n_cmp++; if (ab !== 0) begin n_fail++; $display("FAIL mul_after_done got %0d want 0", ab); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (MdResultE !== 32'd42) begin n_fail++; $display("FAIL mul_hold got %h want 0000002a", MdResultE); end
    endtask

    task automatic test_forwarding();
        int lat, bb, ab; logic [31:0] res;
        do_op(3'd1, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2'b01, 2'b00, lat, res, bb, ab);
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL fwd_mulh got %h want 00000000", res); end
        do_op(3'd0, 32'd7, 32'd1, 32'd0, 32'd6, 2'b00, 2'b10, lat, res, bb, ab);
        n_cmp++; if (res !== 32'd42) begin n_fail++; $display("FAIL fwd_resultw got %h want 0000002a", res); end
        do_op(3'd0, 32'd9, 32'd3, 32'd1, 32'd2, 2'b11, 2'b11, lat, res, bb, ab);
        n_cmp++; if (res !== 32'd27) begin n_fail++; $display("FAIL fwd_reserved got %h want 0000001b", res); end
    endtask

    logic [2:0]  dir_f [10] = '{3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] dir_a [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                                32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b [10] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_r [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14,
                                32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          dir_l [10] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

    task automatic test_directed();
        int lat, bb, ab; logic [31:0] res;
        for (int i = 0; i < 10; i++) begin
            do_op(dir_f[i], dir_a[i], dir_b[i], 32'd0, 32'd0, 2'b00, 2'b00, lat, res, bb, ab);
            n_cmp++;
            if (res !== dir_r[i]) begin
                n_fail++; $display("FAIL directed_%0d_result f3=%0d got %h want %h", i, dir_f[i], res, dir_r[i]);
            end
            n_cmp++;
            if (lat !== dir_l[i] || bb !== 0 || ab !== 0) begin
                n_fail++; $display("FAIL directed_%0d_timing lat=%0d gaps=%0d after=%0d want lat=%0d", i, lat, bb, ab, dir_l[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, bb, ab; logic [31:0] res, a, b, rd1, rd2, m, w, exp;
        logic [2:0] f; logic [1:0] fa, fb;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            rd1 = $urandom; rd2 = $urandom; m = $urandom; w = $urandom;
            fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: begin rd2 = 0; m = 0; w = 0; end
                1: begin rd1 = 32'h8000_0000; m = rd1; w = rd1; rd2 = 32'hFFFF_FFFF; end
                2: begin rd2 = 32'hFFFF_FFFF; m = rd2; w = rd2; end
                default: ;
            endcase
            if (fb == 2'b01) m = (m == 32'h8000_0000) ? 32'hFFFF_FFFF : m;
            a = pick(fa, rd1, m, w);
            b = pick(fb, rd2, m, w);
            exp = model(f, a, b);
            do_op(f, rd1, rd2, m, w, fa, fb, lat, res, bb, ab);
            n_cmp++;
            if (res !== exp) begin
                n_fail++; $display("FAIL random_%0d_result f3=%0d a=%h b=%h got %h want %h", i, f, a, b, res, exp);
            end
            n_cmp++;
            if (lat !== exp_lat(f, a, b) || bb !== 0 || ab !== 0) begin
                n_fail++; $display("FAIL random_%0d_timing lat=%0d gaps=%0d after=%0d want lat=%0d", i, lat, bb, ab, exp_lat(f, a, b));
            end
        end
    endtask

    task automatic test_flush();
        int lat, bb, ab, bad; logic [31:0] res;
        do_op(3'd5, 32'd100, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, lat, res, bb, ab);
        // flush in cycle 10 of a DIV
        @(posedge clk); #1;
        funct3E = 3'd4; RD1E = 32'd1000; RD2E = 32'd3; ValidE = 1; MdE = 1;
        for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
        FlushE = 1;
        @(negedge clk);
        n_cmp++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL flush_div_busy got %b want 0", MdBusy); end
        @(posedge clk); #1;
        idle_inputs();
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (MdDone || MdBusy) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL flush_div_quiet got %0d active cycles want 0", bad); end
        n_cmp++; if (MdResultE !== 32'd14) begin n_fail++; $display("FAIL flush_div_hold got %h want 0000000e", MdResultE); end
        // flush in the DONE cycle
        @(posedge clk); #1;
        funct3E = 3'd0; RD1E = 32'd5; RD2E = 32'd5; ValidE = 1; MdE = 1;
        for (int c = 1; c <= 33; c++) begin @(posedge clk); #1; end
        FlushE = 1;
        @(negedge clk);
        n_cmp++; if (MdDone !== 1'b0 || MdResultE !== 32'd14) begin
            n_fail++; $display("FAIL flush_done got done=%b res=%h want done=0 res=0000000e", MdDone, MdResultE);
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++; if (MdResultE !== 32'd14) begin n_fail++; $display("FAIL flush_done_hold got %h want 0000000e", MdResultE); end
        // flush in the start cycle
        @(posedge clk); #1;
        funct3E = 3'd0; ValidE = 1; MdE = 1; FlushE = 1;
        @(negedge clk);
        n_cmp++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy got %b want 0", MdBusy); end
        @(posedge clk); #1;
        idle_inputs();
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (MdDone || MdBusy) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL flush_start_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_non_m();
        int bad = 0;
        @(posedge clk); #1;
        ValidE = 1; MdE = 0; RD1E = 32'd4; RD2E = 32'd4;
        for (int c = 0; c < 6; c++) begin
            funct3E = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (MdBusy || MdDone) bad++;
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL non_m_quiet got %0d active cycles want 0", bad); end
        n_cmp++; if (MdResultE !== 32'd14) begin n_fail++; $display("FAIL non_m_hold got %h want 0000000e", MdResultE); end
    endtask

    task automatic test_reset_mid();
        int lat, bb, ab; logic [31:0] res;
        @(posedge clk); #1;
        funct3E = 3'd0; RD1E = 32'd11; RD2E = 32'd13; ValidE = 1; MdE = 1;
        for (int c = 1; c <= 5; c++) begin @(posedge clk); #1; end
        reset = 1;
        @(posedge clk); #1;
        reset = 0; idle_inputs();
        @(negedge clk);
        n_cmp++; if (MdBusy !== 0 || MdDone !== 0 || MdResultE !== 0) begin
            n_fail++; $display("FAIL reset_mid_outputs got busy=%b done=%b res=%h want 0 0 0", MdBusy, MdDone, MdResultE);
        end
        do_op(3'd0, 32'd3, 32'd3, 32'd0, 32'd0, 2'b00, 2'b00, lat, res, bb, ab);
        n_cmp++; if (res !== 32'd9 || lat !== 33) begin
            n_fail++; $display("FAIL reset_mid_fresh got res=%h lat=%0d want res=00000009 lat=33", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bb, ab; logic [31:0] res;
        do_op(3'd6, 32'd17, 32'd5, 32'd0, 32'd0, 2'b00, 2'b00, lat, res, bb, ab);
        n_cmp++; if (res !== 32'd2) begin n_fail++; $display("FAIL b2b_first got %h want 00000002", res); end
        do_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 2'b00, 2'b00, lat, res, bb, ab);
        n_cmp++; if (res !== 32'd1 || lat !== 33 || ab !== 0) begin
            n_fail++; $display("FAIL b2b_second got res=%h lat=%0d after=%0d want res=00000001 lat=33 after=0", res, lat, ab);
        end
    endtask

    initial begin
        RD1E = 0; RD2E = 0; ALUResultM = 0; ResultW = 0;
        test_reset();
        test_mul_basic();
        test_forwarding();
        test_directed();
        test_random();
        test_flush();
        test_non_m();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
